// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fetch definitions (icache latency, fetch states, access sizes, in-flight tag)
package ifetch_pkg;
  localparam int ICACHE_LATENCY = 2;
  localparam logic [1:0] ACCESS_SZ_BYTE = 2'd0;
  localparam logic [1:0] ACCESS_SZ_HALF = 2'd1;
  localparam logic [1:0] ACCESS_SZ_WORD = 2'd2;
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_REPLAY = 2'd1,
    ST_HALT   = 2'd2
  } fetch_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        epoch;
  } inflight_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous count-based instruction queue with flush
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch front end with epoch-tagged icache pipe, replay/halt on miss; IFETCH_PERF_EN adds perf counters
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ic_re,
  output logic [31:0] ic_raddr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_hit,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(MAX_RETRY + 1);
  fetch_state_t state, state_n;
  inflight_t pipe [ICACHE_LATENCY];
  inflight_t resp;
  logic [31:0] pc;
  logic [63:0] head;
  logic epoch, req_epoch, cur, miss, push, pop, issue, kill, last_try, bad_target, empty;
  logic [RW-1:0] retry_cnt;
  logic [CW:0] fifo_count;
  int inflight;
  assign resp = pipe[ICACHE_LATENCY-1];
  assign bad_target = redirect_pc[1:0] != 2'b00;
  assign last_try = int'(retry_cnt) + 1 >= MAX_RETRY;
  assign inst_valid = !empty;
  assign inst_pc = head[63:32];
  assign inst_data = head[31:0];
  assign kill = redirect_valid || miss;
  always_comb begin
    inflight = int'(ic_re);
    for (int i = 0; i < ICACHE_LATENCY; i++) inflight += int'(pipe[i].valid);
    cur = resp.valid && resp.epoch == epoch;
    miss = cur && !ic_hit && !redirect_valid;
    push = cur && ic_hit && !redirect_valid;
    pop = inst_valid && inst_ready && !redirect_valid;
    issue = state == ST_RUN && !redirect_valid && !miss && int'(fifo_count) + inflight < FIFO_DEPTH;
    state_n = redirect_valid ? (bad_target ? ST_HALT : ST_RUN) :
              miss ? (last_try ? ST_HALT : ST_REPLAY) :
              state == ST_REPLAY ? ST_RUN : state;
  end
  always_ff @(posedge clk) state <= rst ? ST_RUN : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      epoch <= 1'b0;
      req_epoch <= 1'b0;
      ic_re <= 1'b0;
      ic_raddr <= '0;
      retry_cnt <= '0;
      fetch_fault <= 1'b0;
      fault_pc <= '0;
      for (int i = 0; i < ICACHE_LATENCY; i++) pipe[i] <= '0;
    end else begin
      ic_re <= issue;
      pipe[0] <= '{valid: ic_re && !kill, pc: ic_raddr, epoch: req_epoch};
      for (int i = 1; i < ICACHE_LATENCY; i++) pipe[i] <= '{valid: pipe[i-1].valid && !kill, pc: pipe[i-1].pc, epoch: pipe[i-1].epoch};
      if (issue) begin
        ic_raddr <= pc;
        req_epoch <= epoch;
        pc <= pc + 32'd4;
      end
      if (redirect_valid) begin
        pc <= redirect_pc;
        epoch <= ~epoch;
        retry_cnt <= '0;
        fetch_fault <= bad_target;
        if (bad_target) fault_pc <= redirect_pc;
      end else if (miss) begin
        pc <= resp.pc;
        epoch <= ~epoch;
        retry_cnt <= retry_cnt + 1'b1;
        if (last_try) begin
          fetch_fault <= 1'b1;
          fault_pc <= resp.pc;
        end
      end else if (push) begin
        retry_cnt <= '0;
      end
    end
  end
  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({resp.pc, ic_rdata}),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (fifo_count)
  );
`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_miss_cnt <= '0;
    end else begin
      perf_issue_cnt <= perf_issue_cnt + 32'(ic_re);
      perf_miss_cnt <= perf_miss_cnt + 32'(cur && !ic_hit);
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench with a 2-cycle icache model for ifetch_unit
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_re, ic_hit, inst_valid, fetch_fault;
  logic [31:0] ic_raddr, ic_rdata, inst_data, inst_pc, fault_pc;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic inst_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];
  logic m1_v = 1'b0, m2_v = 1'b0;
  logic [31:0] m1_a = '0, m2_a = '0;
  logic [31:0] miss_addr = 32'hFFFF_FFFF;
  int miss_tag = 0, miss_done = 0;
  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ic_re          (ic_re),
    .ic_raddr       (ic_raddr),
    .ic_rdata       (ic_rdata),
    .ic_hit         (ic_hit),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0] ^ 16'h5A3C};
  endfunction
  assign ic_hit = m2_v && m2_a < 32'h1000 && !(miss_tag != miss_done && m2_a == miss_addr);
  assign ic_rdata = m2_v ? mem_word(m2_a) : 32'h0;
  always @(posedge clk) begin
    m1_v <= ic_re;
    m1_a <= ic_raddr;
    m2_v <= m1_v;
    m2_a <= m1_a;
    if (m2_v && m2_a == miss_addr && miss_tag != miss_done) miss_done <= miss_tag;
  end
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic do_redirect(input logic [31:0] a);
    redirect_pc = a;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask
  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back({base + 32'(4 * i), mem_word(base + 32'(4 * i))});
  endtask
  task automatic test_reset();
    inst_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ic_re, ic_raddr, inst_valid, inst_data, inst_pc, fetch_fault, fault_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got re=%b raddr=%h iv=%b data=%h pc=%h ff=%b fpc=%h, want all 0", ic_re, ic_raddr, inst_valid, inst_data, inst_pc, fetch_fault, fault_pc);
    end
  endtask
  task automatic test_basic();
    logic [63:0] exp;
    logic [31:0] addrs [3];
    int cyc [3];
    int nre, first_iv;
    logic [31:0] first_pc;
    nre = 0;
    first_iv = -1;
    first_pc = 32'hFFFF_FFFF;
    addrs = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    cyc = '{0, 0, 0};
    do_reset();
    inst_ready = 1'b1;
    expect_seq(32'h0, 8);
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      if (ic_re && nre < 3) begin
        addrs[nre] = ic_raddr;
        cyc[nre] = c;
        nre++;
      end
      if (inst_valid && first_iv < 0) begin
        first_iv = c;
        first_pc = inst_pc;
      end
      if (inst_valid && inst_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({inst_pc, inst_data} !== exp) begin
          errors++;
          $display("FAIL basic_inst got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if ({addrs[0], addrs[1], addrs[2]} !== {32'h0, 32'h4, 32'h8}) begin
      errors++;
      $display("FAIL basic_addrs got %h %h %h want 0 4 8", addrs[0], addrs[1], addrs[2]);
    end
    checks++;
    if (cyc[1] - cyc[0] != 1 || cyc[2] - cyc[1] != 1) begin
      errors++;
      $display("FAIL basic_consecutive got cycles %0d %0d %0d want consecutive", cyc[0], cyc[1], cyc[2]);
    end
    checks++;
    if (first_iv - cyc[0] != 3 || first_pc !== 32'h0) begin
      errors++;
      $display("FAIL basic_latency got %0d cycles pc=%h want 3 cycles pc=0", first_iv - cyc[0], first_pc);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL basic_drain got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_backpressure();
    logic [63:0] exp;
    int nre;
    nre = 0;
    do_reset();
    inst_ready = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ic_re) nre++;
    end
    checks++;
    if (nre != 4 || ic_re !== 1'b0) begin
      errors++;
      $display("FAIL bp_issues got %0d issues re=%b want 4 issues re=0", nre, ic_re);
    end
    checks++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL bp_head got iv=%b pc=%h want iv=1 pc=0", inst_valid, inst_pc);
    end
    expect_seq(32'h0, 8);
    inst_ready = 1'b1;
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      if (inst_valid && inst_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({inst_pc, inst_data} !== exp) begin
          errors++;
          $display("FAIL bp_inst got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_redirect();
    logic [63:0] exp;
    do_reset();
    inst_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ic_re, ic_raddr} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL redir_setup got re=%b raddr=%h want re=1 raddr=4", ic_re, ic_raddr);
    end
    expect_seq(32'h100, 6);
    do_redirect(32'h100);
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      if (inst_valid && inst_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({inst_pc, inst_data} !== exp) begin
          errors++;
          $display("FAIL redir_inst got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL redir_drain got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_miss_replay();
    logic [63:0] exp;
    int n8;
    n8 = 0;
    do_reset();
    miss_addr = 32'h8;
    miss_tag++;
    inst_ready = 1'b1;
    expect_seq(32'h0, 8);
    for (int c = 0; c < 100 && sb.size() > 0; c++) begin
      if (ic_re && ic_raddr == 32'h8) n8++;
      if (inst_valid && inst_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({inst_pc, inst_data} !== exp) begin
          errors++;
          $display("FAIL miss_inst got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL miss_drain got %0d left want 0", sb.size());
      sb.delete();
    end
    checks++;
    if (n8 != 2) begin
      errors++;
      $display("FAIL miss_reissue got %0d issues of 0x8 want 2", n8);
    end
    checks++;
    if (dut.retry_cnt !== '0) begin
      errors++;
      $display("FAIL miss_retry_clear got %0d want 0", dut.retry_cnt);
    end
  endtask
  task automatic test_fault();
    logic [63:0] exp;
    int n, nre;
    n = 0;
    nre = 0;
    inst_ready = 1'b1;
    do_redirect(32'h2000);
    for (int c = 0; c < 60 && !fetch_fault; c++) begin
      if (ic_re && ic_raddr == 32'h2000) n++;
      @(negedge clk);
    end
    checks++;
    if ({fetch_fault, fault_pc} !== {1'b1, 32'h2000}) begin
      errors++;
      $display("FAIL fault_halt got ff=%b fpc=%h want ff=1 fpc=2000", fetch_fault, fault_pc);
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL fault_tries got %0d issues of 0x2000 want 3", n);
    end
    repeat (6) begin
      if (ic_re) nre++;
      @(negedge clk);
    end
    checks++;
    if (nre != 0) begin
      errors++;
      $display("FAIL fault_no_issue got %0d issues in halt want 0", nre);
    end
    expect_seq(32'h0, 4);
    do_redirect(32'h0);
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear got ff=%b want 0", fetch_fault);
    end
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      if (inst_valid && inst_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({inst_pc, inst_data} !== exp) begin
          errors++;
          $display("FAIL fault_resume got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fault_drain got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_misaligned();
    int nre;
    nre = 0;
    do_redirect(32'h102);
    checks++;
    if ({fetch_fault, fault_pc} !== {1'b1, 32'h102}) begin
      errors++;
      $display("FAIL misalign_fault got ff=%b fpc=%h want ff=1 fpc=102", fetch_fault, fault_pc);
    end
    repeat (8) begin
      if (ic_re) nre++;
      @(negedge clk);
    end
    checks++;
    if (nre != 0) begin
      errors++;
      $display("FAIL misalign_no_issue got %0d issues want 0", nre);
    end
  endtask
  task automatic test_reset_mid();
    logic [63:0] exp;
    do_reset();
    inst_ready = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_seq(32'h0, 6);
    for (int c = 0; c < 80 && sb.size() > 0; c++) begin
      if (inst_valid && inst_ready) begin
        exp = sb.pop_front();
        checks++;
        if ({inst_pc, inst_data} !== exp) begin
          errors++;
          $display("FAIL rstmid_inst got pc=%h data=%h want pc=%h data=%h", inst_pc, inst_data, exp[63:32], exp[31:0]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rstmid_drain got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_miss_replay();
    test_fault();
    test_misaligned();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
